// File: rtl/voice_phase_scanner_pkg.sv
// Shared synth package: default voice-bank geometry used in common by the
// MIDI decoder, the phase scanner and the oscillator, plus the phase
// scanner state encoding.
package voice_phase_scanner_pkg;

  // Default geometry of the voice bank.
  localparam int unsigned DefaultNumVoices  = 8;
  localparam int unsigned DefaultPhaseWidth = 24;

  // Phase scanner FSM state encoding.
  typedef logic [1:0] scan_state_t;

  localparam scan_state_t StIdle = 2'd0;
  localparam scan_state_t StRd   = 2'd1;
  localparam scan_state_t StLat  = 2'd2;
  localparam scan_state_t StWr   = 2'd3;

endpackage

// File: rtl/voice_phase_scanner.sv
// Voice phase scanner: on each sample tick, sweeps every voice once. For each
// voice it reads the phase and the increment from two block RAMs, registers
// their wrapped sum, and presents it (tagged with the voice index) on a
// valid/ready stream. The phase RAM write-back happens in the same cycle the
// stream beat is accepted.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   sample_tick       one-cycle pulse that starts a sweep
//   ph_addr/din/we    phase RAM port owned by the scanner
//   ph_dout           phase RAM read data (one cycle after the address)
//   inc_addr/dout     increment RAM read port (address always equals ph_addr)
//   out_valid/ready   stream handshake towards the oscillator stage
//   out_voice/phase   voice index and updated phase of the presented beat
//   busy              sweep in progress
//   sweep_done        one-cycle pulse after the last voice is accepted
//   overrun           sticky: a tick arrived while a sweep was still running
module voice_phase_scanner
  import voice_phase_scanner_pkg::*;
#(
  parameter int unsigned NUM_VOICES  = DefaultNumVoices,
  parameter int unsigned VOICE_BITS  = $clog2(NUM_VOICES),
  parameter int unsigned PHASE_WIDTH = DefaultPhaseWidth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  output logic [VOICE_BITS-1:0]  ph_addr,
  output logic [PHASE_WIDTH-1:0] ph_din,
  output logic                   ph_we,
  input  logic [PHASE_WIDTH-1:0] ph_dout,
  output logic [VOICE_BITS-1:0]  inc_addr,
  input  logic [PHASE_WIDTH-1:0] inc_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VOICE_BITS-1:0]  out_voice,
  output logic [PHASE_WIDTH-1:0] out_phase,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun
);

  localparam logic [VOICE_BITS-1:0] LastVoice = VOICE_BITS'(NUM_VOICES - 1);

  scan_state_t            state_q, state_d;
  logic [VOICE_BITS-1:0]  voice_q, voice_d;
  logic [VOICE_BITS-1:0]  out_voice_q, out_voice_d;
  logic [PHASE_WIDTH-1:0] out_phase_q, out_phase_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic [PHASE_WIDTH-1:0] phase_sum;

  // Carry out of the top bit is discarded: phase wraps modulo 2^PHASE_WIDTH.
  assign phase_sum = ph_dout + inc_dout;

  always_comb begin
    state_d     = state_q;
    voice_d     = voice_q;
    out_voice_d = out_voice_q;
    out_phase_d = out_phase_q;
    done_d      = 1'b0;
    // A tick in the sweep_done cycle still belongs to the finished sweep.
    overrun_d   = overrun_q | (sample_tick & ((state_q != StIdle) | done_q));

    case (state_q)
      StIdle: begin
        if (sample_tick && !done_q) begin
          state_d = StRd;
          voice_d = '0;
        end
      end
      StRd: begin
        state_d = StLat;
      end
      StLat: begin
        out_phase_d = phase_sum;
        out_voice_d = voice_q;
        state_d     = StWr;
      end
      StWr: begin
        if (out_ready) begin
          if (voice_q == LastVoice) begin
            done_d  = 1'b1;
            voice_d = '0;
            state_d = StIdle;
          end else begin
            voice_d = voice_q + 1'b1;
            state_d = StRd;
          end
        end
      end
      default: begin
        state_d = StIdle;
        voice_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      voice_q     <= '0;
      out_voice_q <= '0;
      out_phase_q <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      voice_q     <= voice_d;
      out_voice_q <= out_voice_d;
      out_phase_q <= out_phase_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // The address tracks the voice counter in every state, so it is held
  // through LAT and any WR stall.
  assign ph_addr    = voice_q;
  assign inc_addr   = voice_q;
  assign ph_din     = out_phase_q;
  // Gated by rst so a reset cycle never commits a write or a stream beat.
  assign out_valid  = (state_q == StWr) && !rst;
  assign ph_we      = out_valid && out_ready;
  assign out_voice  = out_voice_q;
  assign out_phase  = out_phase_q;
  assign busy       = (state_q != StIdle);
  assign sweep_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_voice_phase_scanner.sv
// Self-checking bench for voice_phase_scanner. The phase and increment RAMs
// are modelled here with one cycle of read latency. Expected outputs for a
// sweep are computed at tick time from the RAM contents.
module tb_voice_phase_scanner;

  localparam int N  = 8;
  localparam int VB = 3;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          out_ready = 1'b0;
  logic [VB-1:0] ph_addr, inc_addr, out_voice;
  logic [PW-1:0] ph_din, out_phase;
  logic [PW-1:0] ph_dout, inc_dout;
  logic          ph_we, out_valid, busy, sweep_done, overrun;

  logic [PW-1:0] phase_mem [N];
  logic [PW-1:0] inc_mem [N];
  logic [PW-1:0] phase_init [N];
  logic          load = 1'b0;

  voice_phase_scanner #(
    .NUM_VOICES (N),
    .VOICE_BITS (VB),
    .PHASE_WIDTH(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .ph_addr    (ph_addr),
    .ph_din     (ph_din),
    .ph_we      (ph_we),
    .ph_dout    (ph_dout),
    .inc_addr   (inc_addr),
    .inc_dout   (inc_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_voice  (out_voice),
    .out_phase  (out_phase),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) begin
      for (int v = 0; v < N; v++) phase_mem[v] <= phase_init[v];
    end else if (ph_we) begin
      phase_mem[ph_addr] <= ph_din;
    end
    ph_dout  <= phase_mem[ph_addr];
    inc_dout <= inc_mem[inc_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  logic [PW-1:0] exp_phase_q [$];
  logic [VB-1:0] exp_voice_q [$];
  logic [PW-1:0] start_phase [N];
  logic [PW-1:0] final_phase [N];
  int            wr_count [N];
  bit            busy_exp, done_exp, ovr_exp;
  int            tick_cyc, stalls, accepted;
  bit            seen_done;
  bit            prev_stall;
  logic [VB-1:0] prev_voice;
  logic [PW-1:0] prev_phase;

  // Stimulus controls.
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stall voice 3 for 5 cycles
  int stall_left = 0;
  bit stall_used = 1'b0;
  bit auto_tick_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    bit acc_now;
    bit busy_next;
    logic [PW-1:0] ev;
    logic [VB-1:0] evo;
    if (rst) begin
      check_eq("ph_we_in_reset", {31'd0, ph_we}, 32'd0);
      check_eq("valid_in_reset", {31'd0, out_valid}, 32'd0);
      exp_phase_q.delete();
      exp_voice_q.delete();
      busy_exp   = 1'b0;
      done_exp   = 1'b0;
      ovr_exp    = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    check_eq("inc_addr_eq_ph_addr", {29'd0, inc_addr}, {29'd0, ph_addr});
    check_eq("sweep_done", {31'd0, sweep_done}, {31'd0, done_exp});
    check_eq("busy", {31'd0, busy}, {31'd0, busy_exp});
    check_eq("overrun", {31'd0, overrun}, {31'd0, ovr_exp});
    if (prev_stall) begin
      check_eq("stall_valid_held", {31'd0, out_valid}, 32'd1);
      check_eq("stall_voice_held", {29'd0, out_voice}, {29'd0, prev_voice});
      check_eq("stall_phase_held", {8'd0, out_phase}, {8'd0, prev_phase});
    end
    if (sweep_done) begin
      seen_done = 1'b1;
      check_eq("done_cycle", cyc, tick_cyc + 1 + 3 * N + stalls);
      check_eq("outputs_per_sweep", accepted, N);
      for (int v = 0; v < N; v++) begin
        check_eq("writes_per_voice", wr_count[v], 1);
        check_eq("ram_after_sweep", {8'd0, phase_mem[v]}, {8'd0, final_phase[v]});
      end
    end
    acc_now = out_valid && out_ready;
    if (acc_now) begin
      check_eq("ph_we_on_accept", {31'd0, ph_we}, 32'd1);
      check_eq("ph_din", {8'd0, ph_din}, {8'd0, out_phase});
      check_eq("ph_addr_on_accept", {29'd0, ph_addr}, {29'd0, out_voice});
      if (exp_voice_q.size() == 0) begin
        check_eq("spurious_output", {31'd0, out_valid}, 32'd0);
      end else begin
        evo = exp_voice_q.pop_front();
        ev  = exp_phase_q.pop_front();
        check_eq("out_voice", {29'd0, out_voice}, {29'd0, evo});
        check_eq("out_phase", {8'd0, out_phase}, {8'd0, ev});
      end
      wr_count[out_voice]++;
      accepted++;
    end else begin
      check_eq("ph_we_idle", {31'd0, ph_we}, 32'd0);
    end
    if (out_valid && !out_ready) stalls++;
    prev_stall = out_valid && !out_ready;
    prev_voice = out_voice;
    prev_phase = out_phase;

    // Advance the model by one cycle.
    busy_next = busy_exp;
    if (sample_tick) begin
      if (busy_exp || done_exp) begin
        ovr_exp = 1'b1;
      end else begin
        tick_cyc = cyc;
        stalls   = 0;
        accepted = 0;
        for (int v = 0; v < N; v++) begin
          wr_count[v]    = 0;
          start_phase[v] = phase_mem[v];
          final_phase[v] = PW'((64'(phase_mem[v]) + 64'(inc_mem[v])) % (64'd1 << PW));
          exp_voice_q.push_back(VB'(v));
          exp_phase_q.push_back(final_phase[v]);
        end
        busy_next = 1'b1;
      end
    end
    done_exp = acc_now && (accepted == N);
    if (done_exp) busy_next = 1'b0;
    busy_exp = busy_next;
  endtask

  task automatic cycle(input bit tick = 1'b0, input bit r = 1'b0, input bit ld = 1'b0);
    @(negedge clk);
    if (ready_mode == 1) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else if (ready_mode == 2) begin
      if (stall_left == 0 && !stall_used && out_valid && out_voice == 3'd3) begin
        stall_left = 5;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end else begin
      out_ready = 1'b1;
    end
    if (auto_tick_done && sweep_done) tick = 1'b1;
    sample_tick = tick;
    rst         = r;
    load        = ld;
    #1;
    monitor();
    cyc++;
  endtask

  // Starts a sweep, optionally with a second tick tick_at cycles later and
  // random extra ticks, and runs until sweep_done is seen.
  task automatic run_sweep(input bit rand_ticks, input int tick_at);
    seen_done = 1'b0;
    cycle(1'b1);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      cycle((i == tick_at - 1) || (rand_ticks && $urandom_range(0, 19) == 0));
    end
    check_eq("sweep_finished", {31'd0, seen_done}, 32'd1);
  endtask

  task automatic load_phases();
    cycle(1'b0, 1'b0, 1'b1);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int v = 0; v < N; v++) begin
      inc_mem[v]    = '0;
      phase_init[v] = '0;
    end

    // Reset and idle.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle();
    check_eq("rst_ph_addr", {29'd0, ph_addr}, 32'd0);
    check_eq("rst_inc_addr", {29'd0, inc_addr}, 32'd0);
    check_eq("rst_ph_din", {8'd0, ph_din}, 32'd0);
    check_eq("rst_out_voice", {29'd0, out_voice}, 32'd0);
    check_eq("rst_out_phase", {8'd0, out_phase}, 32'd0);
    check_eq("rst_ph_we", {31'd0, ph_we}, 32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 10; i++) cycle();

    // Basic sweep: phases 0, increments 0x10*(v+1).
    for (int v = 0; v < N; v++) inc_mem[v] = PW'(32'h10 * (v + 1));
    load_phases();
    run_sweep(1'b0, -1);
    for (int v = 0; v < N; v++) check_eq("basic_ram", {8'd0, phase_mem[v]}, 32'h10 * (v + 1));
    check_eq("basic_latency", cyc - 1 - tick_cyc, 25);
    cycle();

    // Wrap-around on voice 5.
    for (int v = 0; v < N; v++) phase_init[v] = phase_mem[v];
    phase_init[5] = 24'hFFFFF0;
    inc_mem[5]    = 24'h000020;
    load_phases();
    run_sweep(1'b0, -1);
    check_eq("wrap_ram", {8'd0, phase_mem[5]}, 32'h000010);
    cycle();

    // Backpressure: 5 stall cycles on voice 3.
    ready_mode = 2;
    stall_used = 1'b0;
    run_sweep(1'b0, -1);
    check_eq("backpressure_stalls", stalls, 5);
    check_eq("backpressure_latency", cyc - 1 - tick_cyc, 25 + 5);
    ready_mode = 0;
    cycle();

    // Overrun: second tick 10 cycles after the first, then a normal sweep.
    run_sweep(1'b0, 10);
    check_eq("overrun_set", {31'd0, overrun}, 32'd1);
    cycle();
    run_sweep(1'b0, -1);
    check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Tick exactly in the sweep_done cycle is dropped.
    auto_tick_done = 1'b1;
    run_sweep(1'b0, -1);
    auto_tick_done = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Randomized sweeps with random backpressure and stray ticks.
    ready_mode = 1;
    for (int s = 0; s < 6; s++) begin
      for (int v = 0; v < N; v++) begin
        phase_init[v] = PW'($urandom);
        inc_mem[v]    = PW'($urandom);
      end
      load_phases();
      run_sweep(1'b1, -1);
      cycle();
    end
    ready_mode = 0;

    // Reset during LAT of voice 4.
    for (int v = 0; v < N; v++) begin
      phase_init[v] = PW'($urandom);
      inc_mem[v]    = PW'($urandom);
    end
    load_phases();
    seen_done = 1'b0;
    cycle(1'b1);
    for (int i = 0; i < 100 && accepted < 4; i++) cycle();
    check_eq("mid_reset_reached_v4", accepted, 4);
    cycle();                 // RD of voice 4
    cycle(1'b0, 1'b1);       // LAT of voice 4 with reset
    for (int i = 0; i < 4; i++) cycle();
    check_eq("mid_reset_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_reset_idle_valid", {31'd0, out_valid}, 32'd0);
    for (int v = 0; v < N; v++) begin
      check_eq("mid_reset_ram", {8'd0, phase_mem[v]},
               {8'd0, (v < 4) ? final_phase[v] : start_phase[v]});
    end

    // A normal sweep still works after the reset.
    run_sweep(1'b0, -1);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_phase_scanner.md
# voice_phase_scanner

Sweeps all synth voices once per sample tick. For each voice, it reads the phase accumulator and the phase increment from two true-dual-port block RAMs and writes back the wrapped sum. It also streams the updated phase, tagged with the voice index, to the oscillator/wavetable stage over a valid/ready handshake. The scanner exclusively owns one port of the phase RAM and reads one port of the increment RAM; the MIDI control side writes increments through the other increment port.

## Interface
- `NUM_VOICES`, 8: voices per sweep; must be a power of two, at least 2.
- `VOICE_BITS`, 3: equals log2(`NUM_VOICES`); this is the RAM address width.
- `PHASE_WIDTH`, 24: width of phase and increment words.

- `clk` in 1: single clock for the block and both RAM ports it drives.
- `rst` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle pulse that starts a sweep.
- `ph_addr` out `VOICE_BITS`: phase RAM address.
- `ph_din` out `PHASE_WIDTH`: phase RAM write data.
- `ph_we` out 1: phase RAM write enable.
- `ph_dout` in `PHASE_WIDTH`: phase RAM read data, valid one cycle after the address.
- `inc_addr` out `VOICE_BITS`: increment RAM address. Always equal to `ph_addr`.
- `inc_dout` in `PHASE_WIDTH`: increment RAM read data, valid one cycle after the address.
- `out_valid` out 1: an updated phase is presented.
- `out_ready` in 1: downstream accepts the presented phase.
- `out_voice` out `VOICE_BITS`: voice index of the presented phase.
- `out_phase` out `PHASE_WIDTH`: updated phase.
- `busy` out 1: a sweep is in progress.
- `sweep_done` out 1: one-cycle pulse after the last voice is accepted.
- `overrun` out 1: sticky; set when a tick arrives while `busy`. Cleared only by `rst`.

## Operation
- The FSM has four states: IDLE, RD, LAT, WR.
- **IDLE → RD:** taken when `sample_tick` is high. The voice counter is set to 0.
- **RD:** drive `ph_addr` = `inc_addr` = voice. Go to LAT.
- **LAT:** RAM data is valid in this state. Register `ph_dout` + `inc_dout`, truncated to `PHASE_WIDTH` (modulo 2^`PHASE_WIDTH`, carry discarded), into `out_phase`. Register voice into `out_voice`. Go to WR.
- **WR:** `out_valid` = 1.
  - `ph_we` = `out_ready`.
  - `ph_din` = `out_phase`.
  - Address is held at the current voice.
  - On `out_valid && out_ready`:
    - If voice is not `NUM_VOICES`-1: increment voice and go to RD.
    - Otherwise: pulse `sweep_done`, go to IDLE, and reset voice to 0.
  - If `out_ready` is low, stay in WR. Outputs stay stable, and no RAM write occurs.
- Each voice is written exactly once per sweep, and only in the cycle its output is accepted.
- `busy` = 1 in RD, LAT, and WR.
- A `sample_tick` while `busy` is dropped and sets `overrun`. The current sweep is not affected.
- A `sample_tick` in the same cycle that `sweep_done` is asserted counts as an overrun. It does not start a new sweep.

## Timing
- Reset values:
  - State is IDLE, voice is 0.
  - `ph_addr`, `inc_addr`, `ph_din`, `out_voice`, and `out_phase` are 0.
  - `ph_we`, `out_valid`, `busy`, `sweep_done`, and `overrun` are 0.
- Reset applied mid-sweep takes effect on the next edge. No `ph_we` is asserted during or after the reset cycle. The voice currently being processed keeps its old phase.
- Tick sampled at edge t gives the following sequence:
  - RD during cycle t+1.
  - LAT during t+2.
  - WR (`out_valid`) during t+3.
- With `out_ready` held high, each voice takes 3 cycles. A full sweep takes 3·`NUM_VOICES` cycles: 24 for the default.
  - `sweep_done` is high in cycle t+1+3·`NUM_VOICES`.
  - `busy` falls in that same cycle.
- Each stalled cycle adds one cycle of latency.
- An increment written on the other port while the scanner is stalled in WR has no effect on `out_phase`, because the sum was registered in LAT.
- An increment written in the same cycle as the scanner's RD for that voice takes effect per the RAM's read-during-write behaviour, which has no defined ordering. Either the old or the new increment is acceptable.

## Structure
- The shared synth package holds:
  - the state enum (IDLE/RD/LAT/WR);
  - the default `NUM_VOICES` / `PHASE_WIDTH` constants, used in common by the MIDI decoder and the oscillator.
- No sub-module is needed. The RAMs are instantiated one level up using the existing true-dual-port RAM.

## Test plan
- **Reset:** assert `rst` for 2 cycles → every output is 0 and `busy` is 0. Hold `sample_tick` low for 10 cycles → no RAM access.
- **Basic sweep:** phases all 0, increment[v] = 0x10·(v+1), `out_ready` = 1. Tick → outputs are voice 0..7 with phase 0x10..0x80, one every 3 cycles; phase RAM holds the same values; `sweep_done` is high at tick+25.
- **Wrap-around:** phase[5] = 0xFFFFF0, increment[5] = 0x000020 → `out_phase` = 0x000010 for voice 5, and the RAM holds 0x000010.
- **Backpressure:** drive `out_ready` low for 5 cycles while voice 3 is in WR → `out_valid`, `out_voice` = 3, and `out_phase` hold steady; `ph_we` is low; exactly one write to address 3; the sweep ends 5 cycles later than nominal.
- **Overrun:** a second tick 10 cycles after the first → `overrun` = 1 and stays sticky; exactly 8 outputs are produced; a tick after `sweep_done` starts a normal sweep.
- **Reset mid-sweep:** assert `rst` during LAT of voice 4 → no write to address 4; phases 0–3 are updated and phases 4–7 are unchanged; the FSM is IDLE.
